// File: rtl/parity_block_encoder_if.sv
// Stream channel used on both sides of the parity block encoder.
// Carries data/valid/ready/tlast plus sideband fields that the encoder ignores on input and zeroes on output.
interface axi_stream #(
  parameter int DATA_WIDTH = 32
) ();
  localparam int KEEP_WIDTH = (DATA_WIDTH + 7) / 8;

  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;
  logic                  tlast;
  logic [KEEP_WIDTH-1:0] keep;
  logic [3:0]            user;

  modport master (output data, valid, tlast, keep, user, input  ready);
  modport slave  (input  data, valid, tlast, keep, user, output ready);
endinterface

// File: rtl/parity_block_encoder.sv
// Streaming block encoder: forwards data words, then appends one XOR parity word
// after BLOCK_LEN words or an earlier input tlast, so every encoded block XORs to zero.
module parity_block_encoder #(
  parameter int DATA_WIDTH = 32,
  parameter int BLOCK_LEN  = 8
) (
  input  logic        clock,
  input  logic        reset,
  axi_stream.slave    data_in,
  axi_stream.master   data_out,
  output logic [31:0] block_count
);

  localparam int CNT_WIDTH = (BLOCK_LEN < 2) ? 1 : $clog2(BLOCK_LEN + 1);

  typedef enum logic {
    ST_DATA   = 1'b0,
    ST_PARITY = 1'b1
  } state_e;

  if (BLOCK_LEN < 1 || BLOCK_LEN > 65535) begin : g_bad_len
    $error("parity_block_encoder: BLOCK_LEN must be in 1..65535");
  end

  state_e                r_state;
  logic [CNT_WIDTH-1:0]  r_count;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_tlast;
  logic                  r_out_valid;
  logic [31:0]           r_block_count;

  logic w_free;
  logic w_in_ready;
  logic w_in_hs;
  logic w_block_end;
  logic w_unused;

  assign w_free = !r_out_valid || data_out.ready;

  // Gated by reset so the producer sees ready low for as long as reset is held.
  assign w_in_ready  = reset && (r_state == ST_DATA) && w_free;
  assign w_in_hs     = data_in.valid && w_in_ready;
  assign w_block_end = (r_count == CNT_WIDTH'(BLOCK_LEN - 1)) || data_in.tlast;

  assign data_in.ready  = w_in_ready;
  assign data_out.data  = r_out_data;
  assign data_out.valid = r_out_valid;
  assign data_out.tlast = r_out_tlast;
  assign data_out.keep  = '0;
  assign data_out.user  = '0;
  assign block_count    = r_block_count;

  // Sideband input fields carry no meaning for the encoder.
  assign w_unused = ^{data_in.keep, data_in.user};

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_DATA;
      r_count       <= '0;
      r_acc         <= '0;
      r_out_data    <= '0;
      r_out_tlast   <= 1'b0;
      r_out_valid   <= 1'b0;
      r_block_count <= '0;
    end else begin
      case (r_state)
        ST_DATA: begin
          if (w_in_hs) begin
            r_out_data  <= data_in.data;
            r_out_tlast <= 1'b0;
            r_out_valid <= 1'b1;
            r_acc       <= r_acc ^ data_in.data;
            if (w_block_end) begin
              r_state <= ST_PARITY;
              r_count <= '0;
            end else begin
              r_count <= r_count + 1'b1;
            end
          end else if (w_free) begin
            r_out_valid <= 1'b0;
          end
        end
        ST_PARITY: begin
          // The parity load costs one input cycle; the next block waits for it.
          if (w_free) begin
            r_out_data    <= r_acc;
            r_out_tlast   <= 1'b1;
            r_out_valid   <= 1'b1;
            r_acc         <= '0;
            r_block_count <= r_block_count + 32'd1;
            r_state       <= ST_DATA;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parity_block_encoder.sv
// Self-checking bench for parity_block_encoder with BLOCK_LEN 4, 8 and 1 instances,
// a queue-based reference model, directed vector table and randomized backpressure.
module tb_parity_block_encoder;

  localparam int NI = 3;
  localparam int BLS [NI] = '{4, 8, 1};

  typedef struct {
    int          inst;
    bit          reset_before;
    int          first;
    int          n;
    bit          last_flag;
    logic [31:0] exp_parity;
    logic [31:0] exp_count;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n   [NI];
  logic [31:0] d_in    [NI];
  logic        v_in    [NI];
  logic        l_in    [NI];
  logic        rdy_out [NI];

  logic        in_ready [NI];
  logic        o_valid  [NI];
  logic        o_tlast  [NI];
  logic [31:0] o_data   [NI];
  logic [31:0] o_count  [NI];
  logic [3:0]  o_keep   [NI];
  logic [3:0]  o_user   [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    axi_stream #(.DATA_WIDTH(32)) in_if ();
    axi_stream #(.DATA_WIDTH(32)) out_if ();

    assign in_if.data   = d_in[g];
    assign in_if.valid  = v_in[g];
    assign in_if.tlast  = l_in[g];
    assign in_if.keep   = 4'hF;
    assign in_if.user   = 4'hA;
    assign out_if.ready = rdy_out[g];

    assign in_ready[g] = in_if.ready;
    assign o_valid[g]  = out_if.valid;
    assign o_tlast[g]  = out_if.tlast;
    assign o_data[g]   = out_if.data;
    assign o_keep[g]   = out_if.keep;
    assign o_user[g]   = out_if.user;

    parity_block_encoder #(
      .DATA_WIDTH(32),
      .BLOCK_LEN (BLS[g])
    ) u_dut (
      .clock      (clk),
      .reset      (rst_n[g]),
      .data_in    (in_if),
      .data_out   (out_if),
      .block_count(o_count[g])
    );
  end

  // Reference model: expected output beats {tlast, data} per instance.
  bit   [32:0] exp_q [NI][$];
  logic [31:0] m_acc    [NI];
  int          m_cnt    [NI];
  int          m_blocks [NI];
  logic [31:0] last_par [NI];
  logic [31:0] blk_xor  [NI];
  bit          hold_v   [NI];
  logic [31:0] hold_d   [NI];
  logic        hold_l   [NI];

  int n_checks;
  int n_errors;
  bit pat_run;

  logic [31:0] vec_words [28] = '{
    32'h1, 32'h2, 32'h4, 32'h8,
    32'hA5A5A5A5, 32'hA5A5A5A5, 32'h1, 32'h1,
    32'h3, 32'h5, 32'h6, 32'h0,
    32'hDEAD, 32'hBEEF,
    32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8,
    32'h12345678,
    32'h10, 32'h20, 32'h30, 32'h40,
    32'hCAFEF00D
  };
  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic flush(input int i);
    exp_q[i].delete();
    m_acc[i]    = '0;
    m_cnt[i]    = 0;
    m_blocks[i] = 0;
    blk_xor[i]  = '0;
    hold_v[i]   = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    bit [32:0] e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (rst_n[i]) begin
          if (hold_v[i]) begin
            check($sformatf("u%0d stall valid", i), 32'(o_valid[i]), 32'd1);
            check($sformatf("u%0d stall data", i), o_data[i], hold_d[i]);
            check($sformatf("u%0d stall tlast", i), 32'(o_tlast[i]), 32'(hold_l[i]));
          end
          hold_v[i] = o_valid[i] && !rdy_out[i];
          hold_d[i] = o_data[i];
          hold_l[i] = o_tlast[i];
          if (o_valid[i] && rdy_out[i]) begin
            if (exp_q[i].size() == 0) begin
              n_checks++;
              n_errors++;
              $display("FAIL u%0d unexpected beat: got 0x%08h tlast %0b, expected none", i, o_data[i], o_tlast[i]);
            end else begin
              e = exp_q[i].pop_front();
              check($sformatf("u%0d beat data", i), o_data[i], e[31:0]);
              check($sformatf("u%0d beat tlast", i), 32'(o_tlast[i]), 32'(e[32]));
            end
            blk_xor[i] ^= o_data[i];
            if (o_tlast[i]) begin
              check($sformatf("u%0d block xor", i), blk_xor[i], 32'h0);
              blk_xor[i]  = '0;
              last_par[i] = o_data[i];
            end
          end
          if (v_in[i] && in_ready[i]) begin
            exp_q[i].push_back({1'b0, d_in[i]});
            m_acc[i] ^= d_in[i];
            m_cnt[i]++;
            if (m_cnt[i] == BLS[i] || l_in[i]) begin
              exp_q[i].push_back({1'b1, m_acc[i]});
              m_acc[i] = '0;
              m_cnt[i] = 0;
              m_blocks[i]++;
            end
          end
        end
      end
    end
  endtask

  // NOTE: inputs change with blocking assignments 1 time unit after the rising edge.
  task automatic send(input int i, input logic [31:0] d, input logic last, output int waited);
    d_in[i] = d;
    l_in[i] = last;
    v_in[i] = 1'b1;
    waited  = 0;
    forever begin
      @(negedge clk);
      if (in_ready[i]) break;
      waited++;
      if (waited > 500) begin
        n_checks++;
        n_errors++;
        $display("FAIL u%0d send timeout: ready low for %0d cycles, required high", i, waited);
        break;
      end
    end
    step();
  endtask

  task automatic idle(input int i);
    v_in[i] = 1'b0;
    l_in[i] = 1'b0;
  endtask

  task automatic drain(input int i);
    for (int c = 0; c < 500; c++) begin
      if (exp_q[i].size() == 0) break;
      step();
    end
    step();
    check($sformatf("u%0d drain pending", i), 32'(exp_q[i].size()), 32'd0);
  endtask

  task automatic rst(input int i);
    idle(i);
    rst_n[i] = 1'b0;
    flush(i);
    step();
    rst_n[i] = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          w;
    int          w_total;
    logic [31:0] x;
    logic [31:0] rnd;

    n_checks = 0;
    n_errors = 0;
    pat_run  = 1'b0;
    for (int i = 0; i < NI; i++) begin
      rst_n[i]   = 1'b0;
      d_in[i]    = '0;
      v_in[i]    = 1'b0;
      l_in[i]    = 1'b0;
      rdy_out[i] = 1'b1;
      last_par[i] = '0;
      flush(i);
    end

    vecs[0] = '{inst: 0, reset_before: 1, first: 0,  n: 4, last_flag: 0, exp_parity: 32'hF,        exp_count: 32'd1};
    vecs[1] = '{inst: 0, reset_before: 1, first: 4,  n: 4, last_flag: 0, exp_parity: 32'h0,        exp_count: 32'd1};
    vecs[2] = '{inst: 0, reset_before: 0, first: 8,  n: 4, last_flag: 0, exp_parity: 32'h0,        exp_count: 32'd2};
    vecs[3] = '{inst: 1, reset_before: 1, first: 12, n: 2, last_flag: 1, exp_parity: 32'h6042,     exp_count: 32'd1};
    vecs[4] = '{inst: 1, reset_before: 0, first: 14, n: 8, last_flag: 0, exp_parity: 32'h8,        exp_count: 32'd2};
    vecs[5] = '{inst: 2, reset_before: 1, first: 22, n: 1, last_flag: 0, exp_parity: 32'h12345678, exp_count: 32'd1};
    vecs[6] = '{inst: 0, reset_before: 0, first: 23, n: 4, last_flag: 1, exp_parity: 32'h40,       exp_count: 32'd3};
    vecs[7] = '{inst: 2, reset_before: 0, first: 27, n: 1, last_flag: 1, exp_parity: 32'hCAFEF00D, exp_count: 32'd2};

    #2;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("u%0d reset valid", i), 32'(o_valid[i]), 32'd0);
      check($sformatf("u%0d reset data", i), o_data[i], 32'd0);
      check($sformatf("u%0d reset tlast", i), 32'(o_tlast[i]), 32'd0);
      check($sformatf("u%0d reset ready", i), 32'(in_ready[i]), 32'd0);
      check($sformatf("u%0d reset count", i), o_count[i], 32'd0);
    end

    fork
      monitor();
    join_none

    step();
    step();
    for (int i = 0; i < NI; i++) rst_n[i] = 1'b1;
    step();

    // Back-to-back block: one-cycle latency, single input bubble, parity right behind.
    rst(0);
    w_total = 0;
    for (int k = 0; k < 4; k++) begin
      send(0, 32'(1 << k), 1'b0, w);
      w_total += w;
    end
    idle(0);
    check("bubble no stall before parity", 32'(w_total), 32'd0);
    @(negedge clk);
    check("bubble ready low", 32'(in_ready[0]), 32'd0);
    check("last word data", o_data[0], 32'h8);
    check("last word tlast", 32'(o_tlast[0]), 32'd0);
    @(negedge clk);
    check("bubble ready back", 32'(in_ready[0]), 32'd1);
    check("parity follows data", o_data[0], 32'hF);
    check("parity follows tlast", 32'(o_tlast[0]), 32'd1);
    @(negedge clk);
    check("ready stays high", 32'(in_ready[0]), 32'd1);
    check("stream idle after parity", 32'(o_valid[0]), 32'd0);
    step();
    check("bubble block count", o_count[0], 32'd1);
    drain(0);

    for (int v = 0; v < 8; v++) begin
      if (vecs[v].reset_before) rst(vecs[v].inst);
      for (int k = 0; k < vecs[v].n; k++)
        send(vecs[v].inst, vec_words[vecs[v].first + k],
             logic'(vecs[v].last_flag && (k == vecs[v].n - 1)), w);
      idle(vecs[v].inst);
      drain(vecs[v].inst);
      check($sformatf("vec%0d parity", v), last_par[vecs[v].inst], vecs[v].exp_parity);
      check($sformatf("vec%0d count", v), o_count[vecs[v].inst], vecs[v].exp_count);
      check($sformatf("vec%0d model count", v), o_count[vecs[v].inst], 32'(m_blocks[vecs[v].inst]));
    end

    // Asynchronous reset in the middle of a block.
    rst(0);
    for (int k = 0; k < 4; k++) send(0, 32'h11 * (k + 1), 1'b0, w);
    send(0, 32'h55, 1'b0, w);
    send(0, 32'h66, 1'b0, w);
    idle(0);
    check("pre-reset count", o_count[0], 32'd1);
    #2;
    rst_n[0] = 1'b0;
    flush(0);
    #1;
    check("async reset valid", 32'(o_valid[0]), 32'd0);
    check("async reset data", o_data[0], 32'd0);
    check("async reset tlast", 32'(o_tlast[0]), 32'd0);
    check("async reset ready", 32'(in_ready[0]), 32'd0);
    check("async reset count", o_count[0], 32'd0);
    step();
    rst_n[0] = 1'b1;
    step();
    x = '0;
    for (int k = 0; k < 4; k++) begin
      rnd = $urandom;
      x ^= rnd;
      send(0, rnd, 1'b0, w);
    end
    idle(0);
    drain(0);
    check("post-reset parity", last_par[0], x);
    check("post-reset count", o_count[0], 32'd1);

    // Random data and early tlast under a 1,0,0,1 ready pattern.
    rst(0);
    pat_run = 1'b1;
    fork
      begin
        for (int k = 0; pat_run; k++) begin
          rdy_out[0] = ((k % 4) == 0) || ((k % 4) == 3);
          step();
        end
        rdy_out[0] = 1'b1;
      end
    join_none
    for (int k = 0; k < 40; k++)
      send(0, $urandom, logic'($urandom_range(0, 4) == 0), w);
    idle(0);
    pat_run = 1'b0;
    step();
    step();
    drain(0);
    check("random model count", o_count[0], 32'(m_blocks[0]));

    for (int i = 0; i < NI; i++) begin
      check($sformatf("u%0d keep zero", i), 32'(o_keep[i]), 32'd0);
      check($sformatf("u%0d user zero", i), 32'(o_user[i]), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/parity_block_encoder.md
Name: parity_block_encoder

Overview:
Streaming block encoder; the transmit-side counterpart of the syndrome-checking decoder.
- Forwards each input word unchanged.
- After every block of BLOCK_LEN words, or at an earlier input tlast, appends one parity word equal to the XOR of all data words in that block.
- The XOR of every beat in an encoded block (data plus parity) is therefore zero, which is exactly what the decoder's syndrome check tests.
- Sits between an AXI-stream producer and the channel/decoder path.

Parameters:
- DATA_WIDTH, 32: width of the data field on both streams.
- BLOCK_LEN, 8: data words per block before the parity word. Legal range 1..65535.

Ports:
- clock, input, 1: system clock; all logic on the rising edge.
- reset, input, 1: asynchronous active-low reset.
- data_in, axi_stream.slave, DATA_WIDTH: input words.
  - Uses data, valid, ready, tlast.
  - All other fields are ignored.
- data_out, axi_stream.master, DATA_WIDTH: encoded stream.
  - Drives data, valid, tlast.
  - Samples ready.
  - Drives all other fields to 0.
- block_count, output, 32: number of parity words emitted since reset; wraps at 2^32.

Behaviour:
- Reset (reset=0, asynchronous), all of the following cleared immediately:
  - data_out.valid=0, data_out.data=0, data_out.tlast=0.
  - data_in.ready=0, block_count=0.
  - State=DATA, word counter=0, accumulator=0.
  - Reset mid-block discards the partial block; no parity word is emitted for it.
- Output register: one-entry register holding {data, tlast}. It is "free" when data_out.valid=0 or data_out.ready=1.
- State DATA:
  - data_in.ready = free.
  - On an input handshake (valid and ready), in the same cycle:
    - output register <= {input data, tlast=0}; data_out.valid=1 next cycle.
    - accumulator <= accumulator XOR input data.
    - If counter==BLOCK_LEN-1 or input tlast=1: go to PARITY, counter <= 0.
    - Otherwise counter <= counter+1.
  - If free and no handshake: data_out.valid <= 0.
- State PARITY:
  - data_in.ready=0.
  - When free: output register <= {accumulator, tlast=1}, data_out.valid=1, accumulator <= 0, block_count <= block_count+1, go to DATA.
  - While not free: hold; the accumulator keeps the full block parity.
- Latency: each data word appears on data_out 1 cycle after its input handshake. The parity word appears 1 cycle after the last data word leaves (or immediately behind it if data_out.ready stays 1).
- Throughput: with no backpressure, one word per cycle except one input bubble per block (the PARITY cycle). The bubble is mandatory; the first word of the next block is never accepted in the cycle the parity word is loaded.
- Backpressure:
  - data_out.valid, data and tlast stay stable while valid=1 and ready=0.
  - data_in.ready is combinational from data_out.ready and state.
  - There are no combinational paths from data_in to data_out.
- Input tlast:
  - Closes the block early; the parity covers only the words received.
  - tlast on word BLOCK_LEN produces the same result as no tlast.
  - A block can never be empty, because parity is triggered only by a data handshake.
- BLOCK_LEN=1: every word is followed by its own parity word (a copy of the word).
- Counter width: $clog2(BLOCK_LEN+1) bits, minimum 1.

Test Plan:
- BLOCK_LEN=4, data_out.ready=1, inputs 0x1,0x2,0x4,0x8 back-to-back:
  - Output 0x1,0x2,0x4,0x8 (tlast=0), then 0xF (tlast=1).
  - data_in.ready low for exactly one cycle.
  - block_count=1.
- BLOCK_LEN=4, two back-to-back blocks A5A5A5A5,A5A5A5A5,1,1 then 3,5,6,0:
  - Parities 0x00000000 and 0x00000000.
  - Confirms the accumulator clears between blocks; block_count=2.
- BLOCK_LEN=8, input 0xDEAD,0xBEEF with tlast on the second word:
  - Output 0xDEAD, 0xBEEF, then 0x6042 (tlast=1).
  - The next block's counter restarts at 0.
- BLOCK_LEN=4, random data with data_out.ready toggling (pattern 1,0,0,1,...):
  - Output data/tlast stable while stalled; no words lost or duplicated.
  - XOR of each 5-beat block equals 0.
- BLOCK_LEN=4, assert reset=0 asynchronously after 2 words are accepted:
  - Outputs drop to 0 without waiting for a clock edge.
  - After release, 4 new words yield parity over those words only; block_count counts from 0.
- BLOCK_LEN=1, input 0x12345678:
  - Output 0x12345678 (tlast=0), then 0x12345678 (tlast=1).
